// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: memory-latency wait FSM, load-use
// stalls, taken-branch flushes, EX operand forwarding and saturating perf counters.
module pipeline_hazard_unit #(
  parameter int RA_W    = 4,
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [RA_W-1:0]  i_id_ra1,
  input  logic [RA_W-1:0]  i_id_ra2,
  input  logic             i_id_use1,
  input  logic             i_id_use2,
  input  logic [RA_W-1:0]  i_ex_rs1,
  input  logic [RA_W-1:0]  i_ex_rs2,
  input  logic [RA_W-1:0]  i_ex_ra3,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic             i_ex_branch_taken,
  input  logic [RA_W-1:0]  i_mem_ra3,
  input  logic             i_mem_regwrite,
  input  logic             i_mem_access,
  input  logic [RA_W-1:0]  i_wb_ra3,
  input  logic             i_wb_regwrite,
  input  logic             i_clr_cnt,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_mem_wb_bubble,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_dbg_state
);

  localparam bit LAT_GT1 = (MEM_LAT > 1);
  localparam int WC_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [WC_W-1:0]  WC_INIT = WC_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [WC_W-1:0] r_wcnt, w_wcnt_nxt;
  logic            w_freeze;
  logic            w_branch;
  logic            w_load_use;
  logic            w_stall;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // The access's first stall cycle is spent in IDLE, so WAIT only counts the rest.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_freeze    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mem_access && LAT_GT1) begin
          w_freeze    = 1'b1;
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = WC_INIT;
        end
      end
      S_WAIT: begin
        if (r_wcnt != '0) begin
          w_freeze   = 1'b1;
          w_wcnt_nxt = r_wcnt - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_branch   = ~w_freeze & i_ex_branch_taken;
    w_load_use = ~w_freeze & ~i_ex_branch_taken & i_ex_memread & i_ex_regwrite &
                 ((i_id_use1 & (i_id_ra1 == i_ex_ra3)) |
                  (i_id_use2 & (i_id_ra2 == i_ex_ra3)));
    w_stall    = w_freeze | w_load_use;
  end

  always_comb begin
    o_pc_en         = ~w_stall;
    o_if_id_en      = ~w_stall;
    o_id_ex_en      = ~w_freeze;
    o_ex_mem_en     = ~w_freeze;
    o_mem_wb_en     = 1'b1;
    o_if_id_flush   = w_branch;
    o_id_ex_bubble  = w_branch | w_load_use;
    o_mem_wb_bubble = w_freeze;
    o_mem_busy      = w_freeze;
  end

  always_comb begin
    o_fwd_a = 2'b00;
    if (i_mem_regwrite && (i_mem_ra3 == i_ex_rs1))     o_fwd_a = 2'b10;
    else if (i_wb_regwrite && (i_wb_ra3 == i_ex_rs1))  o_fwd_a = 2'b01;
    o_fwd_b = 2'b00;
    if (i_mem_regwrite && (i_mem_ra3 == i_ex_rs2))     o_fwd_b = 2'b10;
    else if (i_wb_regwrite && (i_wb_ra3 == i_ex_rs2))  o_fwd_b = 2'b01;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX))  r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_dbg_state = (r_state == S_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: three instances (different MEM_LAT / CNT_W) share
// one stimulus stream and are compared every cycle against a per-access model.
module tb_pipeline_hazard_unit;

  localparam int NI = 3;
  localparam int LAT_P [NI] = '{3, 4, 1};
  localparam int CW_P  [NI] = '{16, 16, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_ra1, id_ra2, ex_rs1, ex_rs2, ex_ra3, mem_ra3, wb_ra3;
  logic       id_use1, id_use2, ex_regwrite, ex_memread, ex_branch_taken;
  logic       mem_regwrite, mem_access, wb_regwrite, clr_cnt;

  logic [13:0] ctl_o   [NI];
  logic [15:0] stall_o [NI];
  logic [15:0] flush_o [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per instance, whether an access is in progress and how many stall
  // cycles it has already consumed; counters kept as plain integers.
  int m_active [NI];
  int m_done   [NI];
  int m_stall  [NI];
  int m_flush  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int C = CW_P[g];
    logic [C-1:0] sc, fc;
    logic pc, ifid, idex, exmem, memwb, fl, idb, mwb, busy, dbg;
    logic [1:0] fa, fb;
    pipeline_hazard_unit #(.RA_W(4), .MEM_LAT(LAT_P[g]), .CNT_W(C)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_id_ra1(id_ra1), .i_id_ra2(id_ra2), .i_id_use1(id_use1), .i_id_use2(id_use2),
      .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_ra3(ex_ra3),
      .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
      .i_ex_branch_taken(ex_branch_taken),
      .i_mem_ra3(mem_ra3), .i_mem_regwrite(mem_regwrite), .i_mem_access(mem_access),
      .i_wb_ra3(wb_ra3), .i_wb_regwrite(wb_regwrite), .i_clr_cnt(clr_cnt),
      .o_pc_en(pc), .o_if_id_en(ifid), .o_id_ex_en(idex), .o_ex_mem_en(exmem),
      .o_mem_wb_en(memwb), .o_if_id_flush(fl), .o_id_ex_bubble(idb),
      .o_mem_wb_bubble(mwb), .o_fwd_a(fa), .o_fwd_b(fb), .o_mem_busy(busy),
      .o_stall_cnt(sc), .o_flush_cnt(fc), .o_dbg_state(dbg)
    );
    assign ctl_o[g]   = {pc, ifid, idex, exmem, memwb, fl, idb, mwb, busy, dbg, fa, fb};
    assign stall_o[g] = 16'(sc);
    assign flush_o[g] = 16'(fc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [3:0] rs);
    if (mem_regwrite && mem_ra3 == rs) return 2'b10;
    if (wb_regwrite && wb_ra3 == rs)   return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_freeze(input int k);
    if (m_active[k] != 0) return m_done[k] < LAT_P[k] - 1;
    return mem_access && (LAT_P[k] > 1);
  endfunction

  function automatic bit m_load_use();
    return ex_memread && ex_regwrite &&
           ((id_use1 && id_ra1 == ex_ra3) || (id_use2 && id_ra2 == ex_ra3));
  endfunction

  function automatic logic [13:0] exp_ctl(input int k);
    bit frz, br, lu, stl;
    frz = m_freeze(k);
    br  = !frz && ex_branch_taken;
    lu  = !frz && !ex_branch_taken && m_load_use();
    stl = frz || lu;
    return {!stl, !stl, !frz, !frz, 1'b1, br, br || lu, frz, frz,
            m_active[k] != 0, exp_fwd(ex_rs1), exp_fwd(ex_rs2)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_active[k] = 0; m_done[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit frz, br, lu;
      int mx;
      frz = m_freeze(k);
      br  = !frz && ex_branch_taken;
      lu  = !frz && !ex_branch_taken && m_load_use();
      mx  = (1 << CW_P[k]) - 1;
      if (rst) begin
        m_active[k] = 0; m_done[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (m_active[k] != 0) begin
          if (m_done[k] < LAT_P[k] - 1) m_done[k]++;
          else m_active[k] = 0;
        end else if (mem_access && LAT_P[k] > 1) begin
          m_active[k] = 1;
          m_done[k]   = 1;
        end
        if (clr_cnt) begin
          m_stall[k] = 0; m_flush[k] = 0;
        end else begin
          if ((frz || lu) && m_stall[k] < mx) m_stall[k]++;
          if (br && m_flush[k] < mx) m_flush[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("ctl[%0d]", k), 32'(ctl_o[k]), 32'(exp_ctl(k)));
      check($sformatf("stall_cnt[%0d]", k), 32'(stall_o[k]), 32'(m_stall[k]));
      check($sformatf("flush_cnt[%0d]", k), 32'(flush_o[k]), 32'(m_flush[k]));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_quiet();
    id_ra1 = 4'd1; id_ra2 = 4'd2; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_rs1 = 4'd8; ex_rs2 = 4'd9; ex_ra3 = 4'd10; ex_regwrite = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_ra3 = 4'd11;
    mem_regwrite = 1'b0; mem_access = 1'b0; wb_ra3 = 4'd12; wb_regwrite = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    set_quiet();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_ra3 = 4'd5;
    id_ra2 = 4'd5; id_use2 = 1'b1;
  endtask

  initial begin
    set_quiet();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    cycle();
    rst = 1'b0;
    cycle();

    // Single memory access held in MEM
    mem_access = 1'b1;
    cycle();
    mem_access = 1'b0;
    repeat (4) cycle();
    check("lat3_stalls", 32'(stall_o[0]), 32'd2);
    check("lat4_stalls", 32'(stall_o[1]), 32'd3);
    check("lat1_stalls", 32'(stall_o[2]), 32'd0);

    // Load-use, then branch coinciding with load-use
    do_reset();
    set_load_use();
    cycle();
    set_quiet();
    cycle();
    check("lu_stall", 32'(stall_o[0]), 32'd1);
    do_reset();
    set_load_use();
    ex_branch_taken = 1'b1;
    cycle();
    set_quiet();
    cycle();
    check("br_flush", 32'(flush_o[0]), 32'd1);
    check("br_nostall", 32'(stall_o[0]), 32'd0);

    // Forwarding priority, register 0 included
    ex_rs1 = 4'd3; mem_ra3 = 4'd3; wb_ra3 = 4'd3; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    ex_rs2 = 4'd7;
    cycle();
    mem_regwrite = 1'b0;
    cycle();
    ex_rs1 = 4'd0; ex_rs2 = 4'd0; mem_ra3 = 4'd0; mem_regwrite = 1'b1;
    cycle();
    set_quiet();

    // Asynchronous reset one cycle into WAIT
    do_reset();
    mem_access = 1'b1;
    cycle();
    mem_access = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    mem_access = 1'b1;
    cycle();
    mem_access = 1'b0;
    repeat (5) cycle();
    check("lat4_after_rst", 32'(stall_o[1]), 32'd3);

    // Saturation of the 2-bit counters and clear priority
    do_reset();
    repeat (5) begin
      set_load_use();
      cycle();
      set_quiet();
      cycle();
    end
    check("sat_c2", 32'(stall_o[2]), 32'd3);
    set_load_use();
    clr_cnt = 1'b1;
    cycle();
    set_quiet();
    check("clr_c2", 32'(stall_o[2]), 32'd0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_ra1 = 4'($urandom_range(0, 3)); id_ra2 = 4'($urandom_range(0, 3));
      ex_rs1 = 4'($urandom_range(0, 3)); ex_rs2 = 4'($urandom_range(0, 3));
      ex_ra3 = 4'($urandom_range(0, 3)); mem_ra3 = 4'($urandom_range(0, 3));
      wb_ra3 = 4'($urandom_range(0, 3));
      id_use1 = 1'($urandom_range(0, 1)); id_use2 = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      mem_access = ($urandom_range(0, 3) == 0);
      clr_cnt = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 80) == 0);
      #1;
      if (rst) model_reset();
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
